// File: rtl/video_out_hmag_ctrl.sv
// video_out_hmag_ctrl: configuration sequencer for the horizontal magnifier.
//
// CPU writes land in clamped staging registers. A commit snapshots the staging
// values, computes normalize = floor(NORM_NUM / denominator) with a restoring
// serial divider, then waits for the frame boundary and loads all three
// magnifier registers on a single edge.
//
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   reg_write            one-cycle write strobe
//   reg_address          0 = left offset, 1 = denominator, 2 = commit, 3 = reserved
//   reg_wdata            write data (ignored for commit)
//   vdp_hcounter         VDP horizontal counter
//   vdp_vcounter         VDP vertical counter
//   busy                 high while a commit is dividing or waiting for the frame
//   reg_left_offset      magnifier left offset, 0..OFS_MAX
//   reg_denominator      magnifier denominator, DEN_MIN..DEN_MAX
//   reg_normalize        floor(NORM_NUM / reg_denominator)
module video_out_hmag_ctrl #(
  parameter int unsigned DEN_MIN  = 144,
  parameter int unsigned DEN_MAX  = 200,
  parameter int unsigned OFS_MAX  = 112,
  parameter int unsigned NORM_NUM = 8192,
  parameter int unsigned V_APPLY  = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_write,
  input  logic [1:0]  reg_address,
  input  logic [7:0]  reg_wdata,
  input  logic [10:0] vdp_hcounter,
  input  logic [9:0]  vdp_vcounter,
  output logic        busy,
  output logic [7:0]  reg_left_offset,
  output logic [7:0]  reg_denominator,
  output logic [5:0]  reg_normalize
);

  localparam logic [7:0]  DenMin  = 8'(DEN_MIN);
  localparam logic [7:0]  DenMax  = 8'(DEN_MAX);
  localparam logic [7:0]  OfsMax  = 8'(OFS_MAX);
  localparam logic [13:0] NormNum = 14'(NORM_NUM);
  localparam logic [9:0]  VApply  = 10'(V_APPLY);
  localparam logic [5:0]  NormRst = 6'(NORM_NUM / DEN_MAX);
  localparam logic [3:0]  LastIt  = 4'd13;

  typedef enum logic [1:0] {StIdle, StDivide, StWait, StApply} state_e;

  state_e      state_q, state_d;
  logic [7:0]  stage_ofs_q, stage_ofs_d;
  logic [7:0]  stage_den_q, stage_den_d;
  logic        pending_q, pending_d;
  logic [7:0]  work_ofs_q, work_ofs_d;
  logic [7:0]  work_den_q, work_den_d;
  logic [14:0] rem_q, rem_d;
  logic [13:0] dvd_q, dvd_d;
  logic [5:0]  quo_q, quo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [7:0]  out_ofs_q, out_ofs_d;
  logic [7:0]  out_den_q, out_den_d;
  logic [5:0]  out_norm_q, out_norm_d;

  logic        wr_ofs, wr_den, commit, frame_start, fits;
  logic [14:0] rem_sh, rem_sub;

  assign wr_ofs      = reg_write && (reg_address == 2'd0);
  assign wr_den      = reg_write && (reg_address == 2'd1);
  assign commit      = reg_write && (reg_address == 2'd2);
  assign frame_start = (vdp_vcounter == VApply) && (vdp_hcounter == 11'd0);

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  assign rem_sh  = {rem_q[13:0], dvd_q[13]};
  assign fits    = rem_sh >= {7'd0, work_den_q};
  assign rem_sub = rem_sh - {7'd0, work_den_q};

  always_comb begin
    state_d     = state_q;
    stage_ofs_d = stage_ofs_q;
    stage_den_d = stage_den_q;
    pending_d   = pending_q;
    work_ofs_d  = work_ofs_q;
    work_den_d  = work_den_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    out_ofs_d   = out_ofs_q;
    out_den_d   = out_den_q;
    out_norm_d  = out_norm_q;

    if (wr_ofs) begin
      stage_ofs_d = (reg_wdata > OfsMax) ? OfsMax : reg_wdata;
    end
    if (wr_den) begin
      stage_den_d = (reg_wdata < DenMin) ? DenMin :
                    (reg_wdata > DenMax) ? DenMax : reg_wdata;
    end
    // Commits during a running sequence collapse into a single rerun.
    if (commit && (state_q != StIdle)) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (commit || pending_q) begin
          state_d    = StDivide;
          pending_d  = 1'b0;
          work_ofs_d = stage_ofs_q;
          work_den_d = stage_den_q;
          rem_d      = '0;
          dvd_d      = NormNum;
          quo_d      = '0;
          cnt_d      = '0;
        end
      end
      StDivide: begin
        rem_d = fits ? rem_sub : rem_sh;
        dvd_d = {dvd_q[12:0], 1'b0};
        // Only the low 6 quotient bits survive; den >= 129 keeps it below 64.
        quo_d = {quo_q[4:0], fits};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LastIt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (frame_start) begin
          state_d = StApply;
        end
      end
      StApply: begin
        out_ofs_d  = work_ofs_q;
        out_den_d  = work_den_q;
        out_norm_d = quo_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      stage_ofs_q <= 8'd0;
      stage_den_q <= DenMax;
      pending_q   <= 1'b0;
      work_ofs_q  <= 8'd0;
      work_den_q  <= DenMax;
      rem_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_ofs_q   <= 8'd0;
      out_den_q   <= DenMax;
      out_norm_q  <= NormRst;
    end else begin
      state_q     <= state_d;
      stage_ofs_q <= stage_ofs_d;
      stage_den_q <= stage_den_d;
      pending_q   <= pending_d;
      work_ofs_q  <= work_ofs_d;
      work_den_q  <= work_den_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      out_ofs_q   <= out_ofs_d;
      out_den_q   <= out_den_d;
      out_norm_q  <= out_norm_d;
    end
  end

  assign busy            = busy_q;
  assign reg_left_offset = out_ofs_q;
  assign reg_denominator = out_den_q;
  assign reg_normalize   = out_norm_q;

endmodule
